// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered occupancy count,
// programmable almost flags, one-cycle read latency and sticky error flags.
module fifo_sync_param #(
    parameter int DW        = 60,
    parameter int AW        = 9,
    parameter int AF_THRESH = (1 << AW) - 4,
    parameter int AE_THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AF    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] C_AE    = (AW+1)'(AE_THRESH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;
    logic          r_ovf;
    logic          r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;

    // Acceptance uses start-of-cycle flags, so a same-cycle read never frees room
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_wr_ok = we & ~w_full & ~clr;
    assign w_rd_ok = re & ~w_empty & ~clr;

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else if (clr) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_ok) begin
                r_rp   <= r_rp + 1'b1;
                r_dout <= r_mem[r_rp];
            end
            unique case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (we & w_full) begin
                r_ovf <= 1'b1;
            end
            if (re & w_empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign dout         = r_dout;
    assign dout_valid   = r_dout_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AF);
    assign almost_empty = (r_count <= C_AE);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param at DW=8, AW=3 (depth 8).
module tb_fifo_sync_param;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    localparam int AFT = 6;
    localparam int AET = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] sb_q[$];
    int            m_count = 0;
    logic          m_rd = 1'b0;
    logic [DW-1:0] m_dout = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    fifo_sync_param #(
        .DW(DW), .AW(AW), .AF_THRESH(AFT), .AE_THRESH(AET)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_rd = 1'b0;
        m_dout = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // Drive one cycle of stimulus and advance the model at the edge
    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [DW-1:0] d);
        logic wr_ok;
        logic rd_ok;
        @(negedge clk);
        we = w; re = r; clr = c; din = d;
        @(posedge clk);
        if (c) begin
            sb_q.delete();
            m_count = 0;
            m_rd = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            wr_ok = w && (m_count != DEPTH);
            rd_ok = r && (m_count != 0);
            if (w && m_count == DEPTH) m_ovf = 1'b1;
            if (r && m_count == 0) m_udf = 1'b1;
            m_rd = rd_ok;
            if (rd_ok) m_dout = sb_q.pop_front();
            if (wr_ok) sb_q.push_back(d);
            m_count = m_count + int'(wr_ok) - int'(rd_ok);
        end
        #1;
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
            almost_full !== 1'b0 || count !== '0 || dout_valid !== 1'b0 ||
            dout !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset: e=%b ae=%b f=%b af=%b cnt=%0d v=%b d=%h ov=%b un=%b req 1 1 0 0 0 0 00 0 0",
                     empty, almost_empty, full, almost_full, count,
                     dout_valid, dout, overflow, underflow);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b1, 1'b0, 1'b0, (i == 9) ? 8'hFF : DW'(i));
            checks++;
            if (count !== (AW+1)'(m_count) ||
                almost_empty !== (m_count <= AET) ||
                almost_full !== (m_count >= AFT) ||
                full !== (m_count == DEPTH) || empty !== (m_count == 0) ||
                overflow !== m_ovf) begin
                errors++;
                $display("FAIL fill[%0d]: cnt=%0d ae=%b af=%b f=%b ov=%b req cnt=%0d ov=%b",
                         i, count, almost_empty, almost_full, full,
                         overflow, m_count, m_ovf);
            end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (dout_valid !== m_rd || dout !== m_dout ||
                count !== (AW+1)'(m_count)) begin
                errors++;
                $display("FAIL drain[%0d]: v=%b d=%h cnt=%0d req v=%b d=%h cnt=%0d",
                         i, dout_valid, dout, count, m_rd, m_dout, m_count);
            end
        end
        checks++;
        if (empty !== 1'b1 || m_dout !== 8'h08) begin
            errors++;
            $display("FAIL drain_end: empty=%b last=%h req 1 08", empty, m_dout);
        end
    endtask

    task automatic test_empty_wr_rd();
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        checks++;
        if (underflow !== 1'b1 || dout_valid !== 1'b0 || count !== 4'd1 ||
            overflow !== m_ovf) begin
            errors++;
            $display("FAIL empty_wr_rd: un=%b v=%b cnt=%0d ov=%b req 1 0 1 %b",
                     underflow, dout_valid, count, overflow, m_ovf);
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'hAA || dout !== m_dout) begin
            errors++;
            $display("FAIL empty_rd_next: v=%b d=%h req 1 aa", dout_valid, dout);
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, DW'(8'h30 + i));
        cyc(1'b1, 1'b1, 1'b1, 8'h55);
        checks++;
        if (count !== '0 || empty !== 1'b1 || dout_valid !== 1'b0 ||
            overflow !== 1'b0 || underflow !== 1'b0 || dout !== m_dout) begin
            errors++;
            $display("FAIL clr: cnt=%0d e=%b v=%b ov=%b un=%b d=%h req 0 1 0 0 0 %h",
                     count, empty, dout_valid, overflow, underflow, dout, m_dout);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, DW'(8'h40 + i));
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 1'b0, DW'(8'h10 + i));
            checks++;
            if (dout_valid !== 1'b1 || dout !== m_dout || count !== 4'd4) begin
                errors++;
                $display("FAIL b2b[%0d]: v=%b d=%h cnt=%0d req 1 %h 4",
                         i, dout_valid, dout, count, m_dout);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (dout_valid !== 1'b1 || dout !== m_dout ||
                m_dout !== DW'(8'h18 + i)) begin
                errors++;
                $display("FAIL b2b_drain[%0d]: d=%h v=%b req %h",
                         i, dout, dout_valid, DW'(8'h18 + i));
            end
        end
    endtask

    task automatic test_async_rst();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, DW'(8'h60 + i));
        cyc(1'b1, 1'b1, 1'b0, 8'h70);
        we = 1'b1; re = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== '0 || empty !== 1'b1 || almost_empty !== 1'b1 ||
            full !== 1'b0 || almost_full !== 1'b0 || dout_valid !== 1'b0 ||
            dout !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: cnt=%0d e=%b v=%b d=%h ov=%b un=%b req 0 1 0 00 0 0",
                     count, empty, dout_valid, dout, overflow, underflow);
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        rst = 1'b0;
        model_reset();
        cyc(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (dout_valid !== 1'b0 || underflow !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL post_rst: v=%b un=%b cnt=%0d req 0 1 0",
                     dout_valid, underflow, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_empty_wr_rd();
        test_clr();
        test_back_to_back();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
